apb_slave_regs: RTL

APB completer (slave) that sits on one `sels` bit of the APB bus interface and answers master transfers from a small byte-strobed register file. It decodes SETUP/ACCESS phases, inserts a configurable number of wait states, drives `ready`/`rdata`/`error_out` back onto its slot of the bus, and flags address, alignment, read-only and protection violations. One instance per slave device; the bus interface muxes its `ready`/`error_out` to the master by select index.

---
 rtl/apb_slave_regs_pkg.sv | 29 ++
 rtl/apb_slave_regs_if.sv | 29 ++
 rtl/apb_slave_regs_regfile.sv | 38 +++
 rtl/apb_slave_regs.sv | 139 +++++++++++++
 4 files changed

// File: rtl/apb_slave_regs_pkg.sv
// Shared types and constants for the APB register slave.
// Default bus widths are overridable from the build.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // prot bit that marks a privileged access
  localparam int APB_PROT_PRIV = 0;

  // error cause bit positions
  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RO    = 2;
  localparam int ERR_PRIV  = 3;
  localparam int ERR_NUM   = 4;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus slot seen by one completer.
// The master drives the request, the slave the response.
interface apb_slave_regs_if #(
  parameter int ADDR_WIDTH = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `APB_DATA_WIDTH
);

  logic                    sel;
  logic                    penable;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [2:0]              prot;
  logic [DATA_WIDTH/8-1:0] strb;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    error_out;

  modport master (
    output sel, penable, write, addr, prot, strb, wdata,
    input  rdata, ready, error_out
  );

  modport slave (
    input  sel, penable, write, addr, prot, strb, wdata,
    output rdata, ready, error_out
  );

endinterface

// File: rtl/apb_slave_regs_regfile.sv
// Word register array with byte-lane write and async read.
// Reset clears every entry.
module apb_regfile #(
  parameter int REG_NUM    = 16,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(REG_NUM),
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [BYTES-1:0]      strb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [REG_NUM];

  // storage: clear on reset, byte-masked write otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (strb[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with wait states and a byte-strobed register file.
// Responses are driven from registered state only.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = `APB_ADDR_WIDTH,
  parameter int          DATA_WIDTH  = `APB_DATA_WIDTH,
  parameter int          REG_NUM     = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] SLAVE_ID    = 32'h0
) (
  input logic               clk,
  input logic               rst,
  apb_slave_regs_if.slave   bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(REG_NUM);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(REG_NUM * BYTES);
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    WAIT_W'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] ID_VAL =
    DATA_WIDTH'(SLAVE_ID);

  apb_state_e state, state_d;
  logic [WAIT_W-1:0] cnt, cnt_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      strb_q;
  logic                  priv_q;

  logic                  load;
  logic                  commit;
  logic                  done;
  logic                  err;
  logic [ERR_NUM-1:0]    cause;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] reg_rd;
  logic                  unused_prot;

  assign unused_prot = ^bus.prot;

  assign idx = addr_q[OFF_W +: IDX_W];

  // error decode from the fields captured at SETUP
  always_comb begin
    cause = '0;
    cause[ERR_RANGE] = addr_q >= LIMIT;
    cause[ERR_ALIGN] = (addr_q & OFF_MASK) != '0;
    cause[ERR_RO]    = write_q && (idx == '0);
    cause[ERR_PRIV]  = write_q && !priv_q;
  end

  assign err  = |cause;
  assign done = (state == ACCESS) && (cnt == '0);

  // next state, wait counter and write commit
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.sel && !bus.penable) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LOAD;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (!(bus.sel && bus.penable)) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          state_d = IDLE;
          commit  = write_q && !err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and SETUP capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      priv_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) begin
        addr_q  <= bus.addr;
        write_q <= bus.write;
        wdata_q <= bus.wdata;
        strb_q  <= bus.strb;
        priv_q  <= bus.prot[APB_PROT_PRIV];
      end
    end
  end

  apb_regfile #(
    .REG_NUM    (REG_NUM),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .widx  (idx),
    .strb  (strb_q),
    .wdata (wdata_q),
    .ridx  (idx),
    .rdata (reg_rd)
  );

  // response drive, zero outside the completion cycle
  always_comb begin
    bus.ready     = done;
    bus.error_out = done && err;
    bus.rdata     = '0;
    if (done && !err && !write_q) begin
      bus.rdata = (idx == '0) ? ID_VAL : reg_rd;
    end
  end

endmodule
